// File: rtl/scoreboard_issue_ctrl.sv
// In-order issue controller for a 5-stage MIPS pipeline, sitting between IF and ID.
// A shadow shift register tracks destinations still in flight (ID/EXE/MEM). IF is
// stalled on RAW hazards against any of them. Long MDU ops run through a busy FSM.
module scoreboard_issue_ctrl #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LONG_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic        issue_use_rs,
    input  logic        issue_use_rt,
    input  logic        issue_we,
    input  logic [4:0]  issue_waddr,
    input  logic        issue_long,
    input  logic        issue_hilo_rd,
    input  logic        flush,
    output logic        stall,
    output logic        issue_accept,
    output logic        mdu_busy,
    output logic        long_done,
    output logic [31:0] pending
);

    typedef enum logic [0:0] {StIdle, StBusy} mdu_state_e;

    localparam logic [7:0] LatInit = 8'(LONG_LAT - 1);

    logic [DEPTH-1:0] sb_v;
    logic [4:0]       sb_waddr [DEPTH];

    mdu_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       long_done_q, long_done_d;

    logic raw;

    // OR of all valid in-flight destinations; bit 0 is forced low so $0 never matches.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_v[i]) begin
                pending[sb_waddr[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    // Hazard detection and issue handshake.
    always_comb begin
        raw          = (issue_use_rs && pending[issue_rs]) ||
                       (issue_use_rt && pending[issue_rt]);
        stall        = issue_valid && !flush &&
                       (raw || (mdu_busy && (issue_long || issue_hilo_rd)));
        issue_accept = issue_valid && !flush && !stall;
    end

    // Scoreboard shift: sb[0] takes the accepted instruction or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sb_waddr[i] <= '0;
            end
        end else begin
            sb_v[0]     <= issue_accept && issue_we && (issue_waddr != 5'd0);
            sb_waddr[0] <= issue_waddr;
            for (int i = 1; i < DEPTH; i++) begin
                sb_v[i]     <= sb_v[i-1];
                sb_waddr[i] <= sb_waddr[i-1];
            end
        end
    end

    // MDU next-state: count down LONG_LAT cycles; the done pulse lands on the cnt==0 cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        long_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (issue_accept && issue_long) begin
                    state_d = StBusy;
                    cnt_d   = LatInit;
                end
            end
            StBusy: begin
                if (cnt_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d       = cnt_q - 8'd1;
                    long_done_d = (cnt_q == 8'd1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // MDU state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            long_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_done_q <= long_done_d;
        end
    end

    assign mdu_busy  = (state_q == StBusy);
    assign long_done = long_done_q;

endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Randomised bench for scoreboard_issue_ctrl against a cycle-count reference model:
// a register is pending if its latest accepted write is 1..DEPTH cycles old, and the
// MDU is busy for LONG_LAT cycles after a long op is accepted.
module tb_scoreboard_issue_ctrl;

    localparam int DEPTH    = 3;
    localparam int LONG_LAT = 32;
    localparam int NEVER    = -100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs, issue_rt, issue_waddr;
    logic        issue_use_rs, issue_use_rt, issue_we, issue_long, issue_hilo_rd, flush;
    logic        stall, issue_accept, mdu_busy, long_done;
    logic [31:0] pending;

    scoreboard_issue_ctrl #(.DEPTH(DEPTH), .LONG_LAT(LONG_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_we     (issue_we),
        .issue_waddr  (issue_waddr),
        .issue_long   (issue_long),
        .issue_hilo_rd(issue_hilo_rd),
        .flush        (flush),
        .stall        (stall),
        .issue_accept (issue_accept),
        .mdu_busy     (mdu_busy),
        .long_done    (long_done),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int cyc = 0;
    int last_wr [32];
    int acc_cyc = NEVER;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) last_wr[r] = NEVER;
        acc_cyc = NEVER;
    endtask

    // Drive one cycle of inputs, compare outputs against the model, advance one clock.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] wa, input logic lg, input logic hl,
                        input logic fl, input logic r);
        logic [31:0] e_pend;
        logic        e_busy, e_done, e_raw, e_stall, e_acc;
        @(negedge clk);
        issue_valid = v;  issue_rs = rs;  issue_rt = rt;
        issue_use_rs = urs;  issue_use_rt = urt;  issue_we = we;  issue_waddr = wa;
        issue_long = lg;  issue_hilo_rd = hl;  flush = fl;  rst = r;
        #1;
        e_pend = '0;
        for (int k = 1; k < 32; k++) begin
            if ((cyc - last_wr[k]) >= 1 && (cyc - last_wr[k]) <= DEPTH) e_pend[k] = 1'b1;
        end
        e_busy  = (cyc > acc_cyc) && (cyc <= acc_cyc + LONG_LAT);
        e_done  = (cyc == acc_cyc + LONG_LAT);
        e_raw   = (urs && e_pend[rs]) || (urt && e_pend[rt]);
        e_stall = v && !fl && (e_raw || (e_busy && (lg || hl)));
        e_acc   = v && !fl && !e_stall;
        check("stall", 32'(stall), 32'(e_stall));
        check("issue_accept", 32'(issue_accept), 32'(e_acc));
        check("mdu_busy", 32'(mdu_busy), 32'(e_busy));
        check("long_done", 32'(long_done), 32'(e_done));
        check("pending", pending, e_pend);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (e_acc) begin
            if (we && wa != 5'd0) last_wr[wa] = cyc;
            if (lg) acc_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;  issue_valid = 0;  issue_rs = 0;  issue_rt = 0;  issue_use_rs = 0;
        issue_use_rt = 0;  issue_we = 0;  issue_waddr = 0;  issue_long = 0;
        issue_hilo_rd = 0;  flush = 0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // ADDU $3,$1,$2 then ADDU $4,$3,$3: three stall cycles then accept.
        step(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 3, 3, 1, 1, 1, 4, 0, 0, 0, 0);
        idle(4);

        // Producer to $5, independent op, consumer of $5; then two back-to-back producers.
        step(1, 1, 1, 1, 0, 1, 5, 0, 0, 0, 0);
        step(1, 1, 2, 1, 1, 1, 6, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5, 0, 1, 0, 1, 7, 0, 0, 0, 0);
        idle(4);
        step(1, 1, 1, 1, 0, 1, 5, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 1, 5, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 5, 0, 1, 1, 8, 0, 0, 0, 0);
        idle(4);

        // Write $0 then read $0: never stalls, never pending.
        step(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);

        // DIV, ADDU at t+5, MFLO waiting; flush mid-busy; run to completion.
        step(1, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0);
        idle(4);
        step(1, 1, 2, 1, 1, 1, 9, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 10, 0, 1, 0, 0);
        step(1, 9, 9, 1, 1, 1, 11, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 1, 10, 0, 1, 0, 0);
        idle(4);

        // Reset at cycle 10 of a DIV with two writes pending; the pulse must never come.
        step(1, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0);
        idle(7);
        step(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(40);

        // Random traffic on a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 4)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scoreboard_issue_ctrl.md
Name: scoreboard_issue_ctrl

Overview:
- In-order issue controller for the 5-stage MIPS pipeline, sitting between IF and ID.
- Tracks in-flight register writes in a shadow shift register mirroring ID/EXE/MEM.
- Stalls IF on RAW hazards and serialises multi-cycle MDU ops (MULT/DIV) through a busy FSM.
- Replaces per-stage comparator chains with a single scoreboard and pending-write vector.

Parameters:
- DEPTH, 3, number of stages between issue and writeback (ID, EXE, MEM); WB writes regfile before read, so it is not tracked.
- LONG_LAT, 32, cycles a long MDU op occupies the MDU; legal range 2..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- issue_valid  input  1  IF holds a decoded instruction.
- issue_rs  input  5  source register rs.
- issue_rt  input  5  source register rt.
- issue_use_rs  input  1  instruction reads rs.
- issue_use_rt  input  1  instruction reads rt.
- issue_we  input  1  instruction writes the regfile.
- issue_waddr  input  5  destination register.
- issue_long  input  1  instruction is a long MDU op (MULT/MULTU/DIV/DIVU).
- issue_hilo_rd  input  1  instruction reads HI/LO (MFHI/MFLO).
- flush  input  1  branch/jump redirect; kills the instruction currently in IF.
- stall  output  1  hold PC and IF/ID register.
- issue_accept  output  1  instruction enters ID this cycle.
- mdu_busy  output  1  long op in progress.
- long_done  output  1  one-cycle pulse when the long op completes.
- pending  output  32  one-hot OR of valid in-flight destinations; bit 0 always 0.

Behaviour:
- Scoreboard sb[0..DEPTH-1], each entry {v, waddr}. Every cycle sb[i] <= sb[i-1] for i>=1.
- sb[0] <= {issue_we && issue_waddr!=0, issue_waddr} when issue_accept; otherwise sb[0] <= bubble (v=0).
- Entries shifting out of sb[DEPTH-1] retire silently.
- match(r) = r!=0 && there exists i such that sb[i].v && sb[i].waddr==r. All stages are checked, not only the youngest.
- raw = (issue_use_rs && match(issue_rs)) || (issue_use_rt && match(issue_rt)).
- stall = issue_valid && !flush && (raw || (mdu_busy && (issue_long || issue_hilo_rd))). Combinational.
- issue_accept = issue_valid && !flush && !stall. On flush the IF instruction is discarded: no scoreboard entry, no stall. Older entries continue shifting.
- Non-MDU instructions issue freely while mdu_busy; only long ops and HI/LO readers are blocked.
- MDU FSM, states IDLE and BUSY, with 8-bit counter cnt:
  - IDLE -> BUSY when issue_accept && issue_long; cnt <= LONG_LAT-1.
  - BUSY: cnt decrements each cycle. When cnt==0: next state IDLE and long_done=1 for that one cycle (registered).
  - A long op accepted in the same cycle long_done is asserted is impossible, because stall blocks it; its earliest issue is the cycle after long_done.
- mdu_busy = (state==BUSY).
- flush does not abort a running long op.
- pending is the registered-state view: bit r = match(r) for r in 1..31.
- Reset, including mid-BUSY: all sb entries v=0, state IDLE, cnt=0, long_done=0, no completion pulse. Outputs are stall=0, issue_accept=issue_valid, mdu_busy=0, pending=0.
- Writes to $0 never create entries; reads of $0 never stall.

Test Plan:
- Reset then `ADDU $3,$1,$2` (we, waddr=3), then next cycle `ADDU $4,$3,$3` -> stall=1 for exactly 3 cycles; issue_accept=1 on the 4th cycle; pending=0x8 during the stall, then pending=0x0 once the entry retires.
- Producer to $5, one independent instruction, then a consumer of $5 -> consumer stalls 2 cycles; two consecutive producers to $5 -> consumer stalls until the second producer's entry retires.
- Producer writes $0, consumer reads $0 -> stall=0 every cycle, pending=0.
- DIV accepted at cycle t with LONG_LAT=32 -> mdu_busy=1 cycles t+1..t+32, long_done=1 at t+32 only. An ADDU at t+5 is accepted; MFLO at t+5 stalls until t+33.
- RAW stall with flush=1 -> stall=0, issue_accept=0, no scoreboard entry created. Flush during BUSY -> long_done still fires on schedule.
- rst asserted at cycle 10 of a DIV with 2 entries pending -> next cycle pending=0, mdu_busy=0, and long_done never pulses.
